upsampler_stream_expand_fp: RTL and testbench

//  Streaming front end for the dfdd FP upsampler path. Takes a low-res FP image stream and expands it
//  by SCALE in both axes, emitting a raster stream in output-image coordinates.

---
 rtl/upsampler_stream_expand_fp.sv | 169 ++++++++++++++++
 tb/tb_upsampler_stream_expand_fp.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/upsampler_stream_expand_fp.sv
// Streaming FP image upsampler front end: expands each input pixel into a SCALE x SCALE block,
// either zero-inserted (for a following interpolation filter) or nearest-neighbour replicated.
module upsampler_stream_expand_fp #(
    parameter int unsigned EXP_WIDTH    = 5,
    parameter int unsigned FRAC_WIDTH   = 10,
    parameter int unsigned SCALE        = 2,
    parameter int unsigned MAX_IN_WIDTH = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            mode_i,
    input  logic [15:0]                     in_width_i,
    input  logic [15:0]                     in_height_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]   data_i,
    input  logic                            valid_i,
    output logic                            ready_o,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]   data_o,
    output logic [15:0]                     col_o,
    output logic [15:0]                     row_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            frame_done_o
);
    localparam int unsigned FPW = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int unsigned SH  = $clog2(SCALE);
    localparam int unsigned AW  = $clog2(MAX_IN_WIDTH);
    localparam logic [SH-1:0] LAST_PH = SH'(SCALE - 1);

    if (SCALE != 2 && SCALE != 4) begin : g_bad_scale
        $error("upsampler_stream_expand_fp: SCALE must be 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StFill, StReplay, StDone} state_e;

    state_e            state, state_d;
    logic              en_q;
    logic              mode_q;
    logic [15:0]       cfg_w, cfg_h;
    logic [15:0]       in_col, in_row, rp_col;
    logic [SH-1:0]     phase, sub;
    logic [FPW-1:0]    pix;
    logic [FPW-1:0]    line_buf [MAX_IN_WIDTH];

    logic [15:0] w_in, last_col, row_base;
    logic        adv, in_xfer, fill_step, fill_end, rp_row_end, rp_end, done_xfer;

    assign w_in       = (32'(in_width_i) > MAX_IN_WIDTH) ? 16'(MAX_IN_WIDTH) : in_width_i;
    assign last_col   = (cfg_w << SH) - 16'd1;
    assign row_base   = in_row << SH;
    assign adv        = !valid_o || ready_i;
    assign in_xfer    = valid_i && ready_o;
    assign fill_step  = (state == StFill) && (phase != '0) && adv;
    assign fill_end   = fill_step && (phase == LAST_PH) && (in_col == cfg_w - 16'd1);
    assign rp_row_end = (state == StReplay) && adv && (rp_col == last_col);
    assign rp_end     = rp_row_end && (sub == LAST_PH);
    assign done_xfer  = (state == StDone) && valid_o && ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= StIdle;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            StIdle:   if (in_xfer) state_d = StFill;
            StFill:   if (fill_end) state_d = StReplay;
            StReplay: if (rp_end) state_d = (in_row == cfg_h - 16'd1) ? StDone : StFill;
            StDone:   if (done_xfer) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // en_q keeps ready_o low while reset is asserted, without a combinational path from rst_i.
    always_comb begin
        ready_o      = 1'b0;
        frame_done_o = done_xfer;
        if (en_q && adv) begin
            if (state == StIdle) ready_o = (w_in != 16'd0) && (in_height_i != 16'd0);
            else if (state == StFill) ready_o = (phase == '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en_q    <= 1'b0;
            mode_q  <= 1'b0;
            cfg_w   <= '0;
            cfg_h   <= '0;
            in_col  <= '0;
            in_row  <= '0;
            rp_col  <= '0;
            phase   <= '0;
            sub     <= '0;
            pix     <= '0;
            data_o  <= '0;
            col_o   <= '0;
            row_o   <= '0;
            valid_o <= 1'b0;
        end else begin
            en_q <= 1'b1;
            if (adv) valid_o <= 1'b0;
            unique case (state)
                StIdle: if (in_xfer) begin
                    mode_q  <= mode_i;
                    cfg_w   <= w_in;
                    cfg_h   <= in_height_i;
                    in_col  <= '0;
                    in_row  <= '0;
                    pix     <= data_i;
                    phase   <= SH'(1);
                    data_o  <= data_i;
                    col_o   <= '0;
                    row_o   <= '0;
                    valid_o <= 1'b1;
                end
                StFill: begin
                    if (in_xfer) begin
                        pix     <= data_i;
                        phase   <= SH'(1);
                        data_o  <= data_i;
                        col_o   <= in_col << SH;
                        row_o   <= row_base;
                        valid_o <= 1'b1;
                    end else if (fill_step) begin
                        data_o  <= mode_q ? pix : '0;
                        col_o   <= col_o + 16'd1;
                        valid_o <= 1'b1;
                        if (phase == LAST_PH) begin
                            phase <= '0;
                            if (in_col == cfg_w - 16'd1) begin
                                in_col <= '0;
                                rp_col <= '0;
                                sub    <= SH'(1);
                            end else begin
                                in_col <= in_col + 16'd1;
                            end
                        end else begin
                            phase <= phase + SH'(1);
                        end
                    end
                end
                StReplay: if (adv) begin
                    data_o  <= mode_q ? line_buf[rp_col[SH +: AW]] : '0;
                    col_o   <= rp_col;
                    row_o   <= row_base + 16'(sub);
                    valid_o <= 1'b1;
                    if (rp_col == last_col) begin
                        rp_col <= '0;
                        if (sub == LAST_PH) begin
                            sub <= '0;
                            if (in_row != cfg_h - 16'd1) in_row <= in_row + 16'd1;
                        end else begin
                            sub <= sub + SH'(1);
                        end
                    end else begin
                        rp_col <= rp_col + 16'd1;
                    end
                end
                StDone: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_xfer) line_buf[in_col[AW-1:0]] <= data_i;
    end
endmodule

// File: tb/tb_upsampler_stream_expand_fp.sv
// Directed bench for upsampler_stream_expand_fp: SCALE=2 and SCALE=4 instances share stimulus,
// sel picks which one is fed and observed.
module tb_upsampler_stream_expand_fp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, mode, valid_in, ready_in, sel;
    logic [15:0] width, height, din;
    logic        rdy2, v2, fd2, rdy4, v4, fd4;
    logic [15:0] d2, c2, r2, d4, c4, r4;

    int checks = 0;
    int failures = 0;
    logic [15:0] img [0:1023];

    upsampler_stream_expand_fp #(.SCALE(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .in_width_i(width), .in_height_i(height),
        .data_i(din), .valid_i(valid_in && !sel), .ready_o(rdy2), .data_o(d2), .col_o(c2),
        .row_o(r2), .valid_o(v2), .ready_i(ready_in), .frame_done_o(fd2)
    );

    upsampler_stream_expand_fp #(.SCALE(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .mode_i(mode), .in_width_i(width), .in_height_i(height),
        .data_i(din), .valid_i(valid_in && sel), .ready_o(rdy4), .data_o(d4), .col_o(c4),
        .row_o(r4), .valid_o(v4), .ready_i(ready_in), .frame_done_o(fd4)
    );

    wire        o_ready = sel ? rdy4 : rdy2;
    wire        o_valid = sel ? v4 : v2;
    wire        o_done  = sel ? fd4 : fd2;
    wire [15:0] o_data  = sel ? d4 : d2;
    wire [15:0] o_col   = sel ? c4 : c2;
    wire [15:0] o_row   = sel ? r4 : r2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Reference: output (r,c) comes from input (r/s, c/s); ZERO keeps only the block's top-left.
    function automatic logic [15:0] want_pix(input bit md, input int s, input int w, input int idx);
        int r, c;
        logic [15:0] p;
        r = idx / (s * w);
        c = idx % (s * w);
        p = img[(r / s) * w + c / s];
        if (md || (r % s == 0 && c % s == 0)) return p;
        return 16'h0000;
    endfunction

    task automatic run_frame(input bit md, input int w, input int h, input bit toggle,
                             input bit gaps, input int abort_after, output int span);
        int s, total, n, in_idx, out_idx, cyc, first_acc, budget;
        bit done, stalled, prev_acc;
        logic [47:0] held;
        s = sel ? 4 : 2;
        total = s * s * w * h;
        n = w * h;
        in_idx = 0; out_idx = 0; cyc = 0; first_acc = -1; span = 0;
        done = 0; stalled = 0; prev_acc = 0; held = '0;
        budget = 4 * total + 50;
        mode = md; width = 16'(w); height = 16'(h);
        while (!done && cyc < budget) begin
            valid_in = (in_idx < n) && (!gaps || $urandom_range(0, 2) != 0);
            din = (in_idx < n) ? img[in_idx] : 16'h0000;
            ready_in = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (stalled) check("stall_hold", {o_valid, o_data, o_col, o_row}, {1'b1, held});
            if (prev_acc) check("ready_gap", o_ready, 1'b0);
            if (o_valid && ready_in) begin
                check("data", o_data, want_pix(md, s, w, out_idx));
                check("col", o_col, out_idx % (s * w));
                check("row", o_row, out_idx / (s * w));
                check("frame_done", o_done, out_idx == total - 1);
                if (out_idx == total - 1) begin
                    done = 1;
                    span = cyc - first_acc;
                end
                out_idx++;
            end else begin
                check("done_idle", o_done, 1'b0);
            end
            stalled = o_valid && !ready_in;
            held = {o_data, o_col, o_row};
            prev_acc = valid_in && o_ready;
            if (prev_acc) begin
                if (first_acc < 0) first_acc = cyc;
                in_idx++;
            end
            if (abort_after > 0 && out_idx == abort_after) return;
            @(posedge clk);
            #1;
            cyc++;
        end
        valid_in = 0;
        check("frame_end", done, 1'b1);
        check("n_out", out_idx, total);
        check("n_in", in_idx, n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int span;
        sel = 0; rst = 0; mode = 0; valid_in = 0; ready_in = 1;
        width = 16'd2; height = 16'd2; din = 16'h0;
        #1 rst = 1;
        #2;
        check("rst_valid", v2, 1'b0);
        check("rst_ready", rdy2, 1'b0);
        check("rst_done", fd2, 1'b0);
        check("rst_data", d2, 16'h0);
        check("rst_col", c2, 16'h0);
        check("rst_row", r2, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;
        img[0] = 16'h3C00; img[1] = 16'h4000; img[2] = 16'h4200; img[3] = 16'h4400;

        run_frame(0, 2, 2, 0, 0, 0, span);
        check("t1_span", span, 16);
        run_frame(1, 2, 2, 0, 0, 0, span);
        check("t2_span", span, 16);
        run_frame(0, 2, 2, 1, 1, 0, span);

        run_frame(0, 2, 2, 0, 0, 5, span);
        valid_in = 0;
        rst = 1;
        #1;
        check("t4_valid", v2, 1'b0);
        check("t4_ready", rdy2, 1'b0);
        check("t4_col", c2, 16'h0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk);
        #1;
        run_frame(0, 2, 2, 0, 0, 0, span);
        check("t4_span", span, 16);

        width = 16'd0; height = 16'd2; valid_in = 1; din = 16'h3C00;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("w0_ready", o_ready, 1'b0);
            check("w0_valid", o_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        valid_in = 0;
        for (int i = 0; i < 1024; i++) img[i] = 16'(16'h1000 + i);
        run_frame(1, 1024, 1, 0, 0, 0, span);
        check("t5_span", span, 4096);

        sel = 1;
        img[0] = 16'h4500;
        run_frame(0, 1, 1, 0, 0, 0, span);
        check("t6_span", span, 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
